// File: rtl/pipe_seq_pkg.sv
// pipe_seq_pkg: shared state encoding and drain-counter sizing for pipeline_sequencer
package pipe_seq_pkg;
  typedef enum logic [1:0] {PS_IDLE, PS_RUN, PS_DRAIN, PS_DONE} pipe_state_e;
  function automatic int drain_w(input int dc);
    return $clog2(dc + 1);
  endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds an operand read in ID
module load_use_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  i_ex_memread,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rd,
  output logic                  o_stall
);
  assign o_stall = i_ex_memread & ((i_id_uses_rs & (i_ex_rd == i_id_rs)) | (i_id_uses_rd & (i_ex_rd == i_id_rd)));
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: start/run/drain/done controller driving IF/ID and ID/EX enables, flushes and bubbles; PIPE_SEQ_PERF_EN enables the perf counters
import pipe_seq_pkg::*;
module pipeline_sequencer #(
  parameter int NUM_STAGES   = 5,
  parameter int REG_ADDR_W   = 3,
  parameter int DRAIN_CYCLES = NUM_STAGES - 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_id,
  input  logic                  branch_id,
  input  logic                  exc_req,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rd,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_kill,
  output logic                  running,
  output logic                  done,
  output logic                  exc_flag,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      stall_count
);
  localparam int DW = drain_w(DRAIN_CYCLES);
  if (NUM_STAGES < 3 || DRAIN_CYCLES < 1) begin : g_bad_cfg
    $error("pipeline_sequencer: NUM_STAGES must be >=3 and DRAIN_CYCLES >=1");
  end
  pipe_state_e r_state, w_next;
  logic [DW-1:0] r_drain;
  logic r_exc;
  logic w_stall, w_start, w_launch;
  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .i_ex_memread(ex_memread),
    .i_ex_rd     (ex_rd),
    .i_id_rs     (id_rs),
    .i_id_rd     (id_rd),
    .i_id_uses_rs(id_uses_rs),
    .i_id_uses_rd(id_uses_rd),
    .o_stall     (w_stall)
  );
  // reset beats a coincident start, so start is masked while reset is high
  assign w_start  = start & ~reset;
  assign w_launch = w_start & ((r_state == PS_IDLE) | (r_state == PS_DONE));
  assign running  = r_state == PS_RUN;
  assign done     = r_state == PS_DONE;
  assign exc_flag = r_exc;
  // next state and pipeline controls; exception outranks halt, halt outranks branch, and a stall defers both
  always_comb begin
    w_next      = r_state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_kill  = 1'b0;
    case (r_state)
      PS_IDLE, PS_DONE: begin
        ifid_flush  = w_start;
        idex_bubble = w_start;
        w_next      = w_start ? PS_RUN : r_state;
      end
      PS_RUN: begin
        pc_en       = ~w_stall;
        ifid_en     = ~w_stall;
        idex_bubble = w_stall;
        if (exc_req) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_kill  = 1'b1;
          pc_en       = 1'b0;
          w_next      = PS_DRAIN;
        end else if (halt_id && !w_stall) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          pc_en       = 1'b0;
          w_next      = PS_DRAIN;
        end else if (branch_id && !w_stall) begin
          ifid_flush = 1'b1;
        end
      end
      default: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        w_next      = (r_drain == '0) ? PS_DONE : PS_DRAIN;
      end
    endcase
  end
  // state, drain countdown (preloaded every RUN cycle so it is ready on entry) and sticky exception flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PS_IDLE;
      r_drain <= '0;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drain <= (r_state == PS_RUN) ? DW'(DRAIN_CYCLES - 1) : (r_drain != '0) ? r_drain - DW'(1) : r_drain;
      r_exc   <= w_launch ? 1'b0 : (running & exc_req) ? 1'b1 : r_exc;
    end
  end
`ifdef PIPE_SEQ_PERF_EN
  logic [CNT_W-1:0] r_cyc, r_stl;
  // saturating perf counters, cleared by reset or a new run
  always_ff @(posedge clk) begin
    if (reset || w_launch) begin
      r_cyc <= '0;
      r_stl <= '0;
    end else begin
      if ((running || r_state == PS_DRAIN) && !(&r_cyc)) r_cyc <= r_cyc + CNT_W'(1);
      if (running && w_stall && !(&r_stl)) r_stl <= r_stl + CNT_W'(1);
    end
  end
  assign cycle_count = r_cyc;
  assign stall_count = r_stl;
`else
  assign cycle_count = '0;
  assign stall_count = '0;
`endif
endmodule
